// File: rtl/systolic_skew_feeder.sv
// Operand staging and diagonal skew feeder for the 5x5 systolic PE array.
// Holds one A tile (rows x K) and one B tile (K x cols). On go, it streams the
// tiles into the array lanes with a per-lane diagonal delay, asserts start for
// the whole stream, and then waits for the array's done pulse.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_DIM  = 5,
  parameter int KMAX       = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic                            wr_sel,
  input  logic [2:0]                      wr_row,
  input  logic [2:0]                      wr_col,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            go,
  input  logic [2:0]                      filter_size,
  input  logic                            array_done,
  output logic                            busy,
  output logic                            start,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] a_out,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] b_out,
  output logic [2:0]                      k_out,
  output logic                            tile_done,
  output logic                            err
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

  localparam logic [2:0] DIM_LIM = 3'(ARRAY_DIM);
  localparam logic [2:0] K_LIM   = 3'(KMAX);

  state_t                          state_q, state_d;
  logic [3:0]                      t_q, t_d;
  logic [2:0]                      k_q, k_d;
  logic                            start_q, start_d;
  logic                            tile_done_q, tile_done_d;
  logic                            err_q, err_d;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] a_lane_q, a_lane_d;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] b_lane_q, b_lane_d;
  logic [3:0]                      last_t;
  logic [3:0]                      lane_off;

  // A buffer indexed [row i][k], B buffer indexed [k][col j]
  logic [DATA_WIDTH-1:0] a_buf_q [ARRAY_DIM][KMAX];
  logic [DATA_WIDTH-1:0] a_buf_d [ARRAY_DIM][KMAX];
  logic [DATA_WIDTH-1:0] b_buf_q [KMAX][ARRAY_DIM];
  logic [DATA_WIDTH-1:0] b_buf_d [KMAX][ARRAY_DIM];

  // Final stream cycle: the array's last-row completion count K+8
  assign last_t = {1'b0, k_q} + 4'd8;

  // Tile buffer write port: only open in IDLE, out-of-range indices dropped
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (wr_en && state_q == IDLE) begin
      if (!wr_sel) begin
        if (wr_row < DIM_LIM && wr_col < K_LIM) a_buf_d[wr_row][wr_col] = wr_data;
      end else begin
        if (wr_row < K_LIM && wr_col < DIM_LIM) b_buf_d[wr_row][wr_col] = wr_data;
      end
    end
  end

  // Control FSM next-state: go validation, stream counter, done handshake
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    k_d         = k_q;
    err_d       = 1'b0;
    tile_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (filter_size != 3'd0 && filter_size <= K_LIM) begin
            k_d     = filter_size;
            t_d     = 4'd0;
            state_d = STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (t_q == last_t) state_d = WAIT_DONE;
        else               t_d     = t_q + 4'd1;
      end
      WAIT_DONE: begin
        if (array_done) begin
          tile_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skewed lane data: lane n is delayed by n cycles, zero outside its K-window
  always_comb begin
    start_d  = (state_q == STREAM);
    a_lane_d = '0;
    b_lane_d = '0;
    lane_off = '0;
    if (state_q == STREAM) begin
      for (int n = 0; n < ARRAY_DIM; n++) begin
        lane_off = t_q - 4'(n);
        if (t_q >= 4'(n) && lane_off < {1'b0, k_q}) begin
          a_lane_d[n*DATA_WIDTH +: DATA_WIDTH] = a_buf_q[n][lane_off[2:0]];
          b_lane_d[n*DATA_WIDTH +: DATA_WIDTH] = b_buf_q[lane_off[2:0]][n];
        end
      end
    end
  end

  // State, buffers and registered outputs; reset clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      k_q         <= '0;
      start_q     <= 1'b0;
      tile_done_q <= 1'b0;
      err_q       <= 1'b0;
      a_lane_q    <= '0;
      b_lane_q    <= '0;
      a_buf_q     <= '{default: '0};
      b_buf_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      k_q         <= k_d;
      start_q     <= start_d;
      tile_done_q <= tile_done_d;
      err_q       <= err_d;
      a_lane_q    <= a_lane_d;
      b_lane_q    <= b_lane_d;
      a_buf_q     <= a_buf_d;
      b_buf_q     <= b_buf_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign start     = start_q;
  assign a_out     = a_lane_q;
  assign b_out     = b_lane_q;
  assign k_out     = k_q;
  assign tile_done = tile_done_q;
  assign err       = err_q;

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Operand staging and skew stage directly upstream of the 5x5 FP16 systolic PE array.
- Holds one A tile (5 rows x K) and one B tile (K x 5 columns), loaded through a write port.
- On `go`, streams the tiles into the array's A-row and B-column inputs with per-lane diagonal skew, drives the array's `start`, then waits for the array's `done` pulse before accepting the next tile.

Parameters:
- DATA_WIDTH, 16, operand width (FP16 bit pattern; never interpreted, only moved).
- ARRAY_DIM, 5, number of A lanes and B lanes; fixed at 5 to match the array.
- KMAX, 5, maximum inner dimension K (filter_size).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  tile buffer write strobe.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_row  in  3  A: array row i (0..4); B: k index (0..4).
- wr_col  in  3  A: k index (0..4); B: array column j (0..4).
- wr_data  in  DATA_WIDTH  operand value.
- go  in  1  request to stream the loaded tile.
- filter_size  in  3  K, sampled at go; legal range 1..5.
- array_done  in  1  done pulse from the PE array.
- busy  out  1  high outside IDLE.
- start  out  1  to array start.
- a_out  out  ARRAY_DIM*DATA_WIDTH  lane i at bits [i*DW +: DW]; drives array row-i A input.
- b_out  out  ARRAY_DIM*DATA_WIDTH  lane j at bits [j*DW +: DW]; drives array column-j B input.
- k_out  out  3  latched K; drives array filter_size.
- tile_done  out  1  one-cycle pulse when the tile completes.
- err  out  1  one-cycle pulse when go is rejected.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset state:
  - All outputs 0.
  - FSM in IDLE.
  - All 50 buffer entries cleared to 0.
  - Reset overrides every other input, including mid-stream; start drops on the next edge.
- Writes:
  - Accepted only in IDLE. wr_en while busy=1 is ignored.
  - Out-of-range indices (>4) are ignored.
  - A write and a go in the same IDLE cycle: the write lands first, so the stream sees the new value.
- FSM states: IDLE, STREAM, WAIT_DONE.
- IDLE:
  - go with filter_size in 1..5: latch K into k_out, clear the stream counter t to 0, go to STREAM.
  - go with filter_size 0, 6 or 7: err=1 for one cycle, stay in IDLE, k_out unchanged.
- STREAM:
  - Lasts exactly K+9 cycles (t = 0 .. K+8). This matches the array's row-5 completion count K+8, plus one.
  - start=1 throughout.
  - All outputs are registered. If go is sampled at edge n, start and the t=0 lane data are visible after edge n+1.
  - After t = K+8, go to WAIT_DONE with start=0.
- Lane data at cycle t, for lane i / j in 0..4:
  - a_out lane i = A[i][t-i] if 0 <= t-i < K, else 0.
  - b_out lane j = B[t-j][j] if 0 <= t-j < K, else 0.
  - Zeros are the padding; the last nonzero element appears at t = K+3.
- WAIT_DONE:
  - start=0, lanes 0.
  - On array_done=1: tile_done=1 for one cycle, go to IDLE.
  - array_done in any other state is ignored.
  - There is no timeout. reset is the only escape.
- busy: combinational from state, 1 in STREAM and WAIT_DONE.
- go outside IDLE is ignored, with no err.
- Buffer contents persist across tiles, so go can be reissued without reloading.
- Counter t is 4 bits and never wraps; K+8 is at most 13.

Test Plan:
- Load A[i][k]=0x3C00+i*16+k and B[k][j]=0x4000+k*16+j, go with K=3. Required:
  - start high for 12 cycles.
  - a_out lane 2 is 0,0,0x3C20,0x3C21,0x3C22,0... .
  - b_out lane 4 is 0 until t=4, then 0x4004,0x4014,0x4024, then 0.
- K=5 full tile: start high 14 cycles. a_out lane 4 last nonzero at t=8 (0x3C44). After start falls, a pulse on array_done gives tile_done=1 exactly one cycle later and busy=0.
- go with filter_size=0 and with filter_size=6: err pulses once each, busy stays 0, start never rises.
- Mid-STREAM (t=5) apply wr_en to A[0][0] and a second go: buffer value unchanged on readback via a re-stream, no restart, start length still K+9.
- Assert reset at t=3 of a stream:
  - The next cycle has start=0, all lanes 0, busy=0.
  - A re-go after reset streams all zeros, since the buffer was cleared.
- In IDLE, write A[1][0]=0x1234 in the same cycle as go (K=1): a_out lane 1 shows 0x1234 at t=1.
